// File: rtl/delay_path_sequencer.sv
// Launches alternating transitions into an external delay path and, after a
// programmable settle time, checks the captured output for each trial.
module delay_path_sequencer #(
  parameter int   TRIAL_W   = 16,
  parameter int   SETTLE_W  = 8,
  parameter int   CNT_W     = 16,
  parameter logic INVERTING = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [TRIAL_W-1:0]  num_trials,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                path_in,
  input  logic                path_result,
  output logic                busy,
  output logic                done,
  output logic [TRIAL_W-1:0]  trial_count,
  output logic [CNT_W-1:0]    err_rise,
  output logic [CNT_W-1:0]    err_fall,
  output logic [TRIAL_W-1:0]  first_fail
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]          r_state;
  logic                r_path_in;
  logic                r_rise;
  logic [SETTLE_W-1:0] r_cnt;
  logic [SETTLE_W-1:0] r_settle;
  logic [TRIAL_W-1:0]  r_num;
  logic                r_capture;
  logic [TRIAL_W-1:0]  r_trial;
  logic [CNT_W-1:0]    r_err_rise;
  logic [CNT_W-1:0]    r_err_fall;
  logic [TRIAL_W-1:0]  r_first;

  logic [SETTLE_W-1:0] w_settle_eff;
  logic                w_pass;
  logic                w_cap_edge;
  logic [TRIAL_W-1:0]  w_trial_next;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TRIAL_W-1:0] sat_inc_trial(input logic [TRIAL_W-1:0] v);
    return (&v) ? v : v + TRIAL_W'(1);
  endfunction

  assign w_settle_eff = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
  assign w_pass       = (r_capture == (r_path_in ^ INVERTING));
  assign w_cap_edge   = (r_state == S_WAIT) && (r_cnt == SETTLE_W'(1));
  assign w_trial_next = sat_inc_trial(r_trial);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_path_in  <= 1'b0;
      r_rise     <= 1'b0;
      r_cnt      <= '0;
      r_trial    <= '0;
      r_err_rise <= '0;
      r_err_fall <= '0;
      r_first    <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_trial    <= '0;
            r_err_rise <= '0;
            r_err_fall <= '0;
            r_first    <= '1;
            r_state    <= (num_trials == '0) ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_path_in <= ~r_path_in;
            r_rise    <= ~r_path_in;
            r_cnt     <= r_settle;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - SETTLE_W'(1);
            if (w_cap_edge) r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          // abort discards this trial's result entirely
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            if (!w_pass) begin
              if (r_rise) r_err_rise <= sat_inc_cnt(r_err_rise);
              else        r_err_fall <= sat_inc_cnt(r_err_fall);
              if (&r_first) r_first <= r_trial;
            end
            r_trial <= w_trial_next;
            r_state <= (w_trial_next == r_num) ? S_DONE : S_LAUNCH;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Run parameters and the path capture carry no reset: only meaningful once a run starts.
  // The capture flop is deliberately unsynchronized; it measures the raw path.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && start) begin
      r_num    <= num_trials;
      r_settle <= w_settle_eff;
    end
    if (w_cap_edge) r_capture <= path_result;
  end

  assign path_in     = r_path_in;
  assign busy        = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign done        = (r_state == S_DONE);
  assign trial_count = r_trial;
  assign err_rise    = r_err_rise;
  assign err_fall    = r_err_fall;
  assign first_fail  = r_first;

endmodule

// File: tb/tb_delay_path_sequencer.sv
// Bench for delay_path_sequencer: a behavioural inverting delay path with a
// selectable delay drives a full-width instance and a narrow-counter instance.
module tb_delay_path_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_trials;
  logic [7:0]  settle_cycles;
  logic [4:0]  tap_sel;

  logic        path_in_a, path_result_a, busy_a, done_a;
  logic [15:0] trial_count_a, err_rise_a, err_fall_a, first_fail_a;
  logic        path_in_b, path_result_b, busy_b, done_b;
  logic [15:0] trial_count_b, first_fail_b;
  logic [1:0]  err_rise_b, err_fall_b;

  logic [30:0] hist_a = '0;
  logic [30:0] hist_b = '0;
  logic [31:0] taps_a, taps_b;

  int n_checks = 0;
  int n_fail   = 0;

  delay_path_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_trials(num_trials), .settle_cycles(settle_cycles),
    .path_in(path_in_a), .path_result(path_result_a),
    .busy(busy_a), .done(done_a), .trial_count(trial_count_a),
    .err_rise(err_rise_a), .err_fall(err_fall_a), .first_fail(first_fail_a)
  );

  delay_path_sequencer #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_trials(num_trials), .settle_cycles(settle_cycles),
    .path_in(path_in_b), .path_result(path_result_b),
    .busy(busy_b), .done(done_b), .trial_count(trial_count_b),
    .err_rise(err_rise_b), .err_fall(err_fall_b), .first_fail(first_fail_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Path of delay D: output shows ~path_in D-1 edges after the launch edge,
  // so a capture S edges after launch sees the new value iff D <= S.
  always @(posedge clk) begin
    hist_a <= {hist_a[29:0], path_in_a};
    hist_b <= {hist_b[29:0], path_in_b};
  end
  assign taps_a        = {hist_a, path_in_a};
  assign taps_b        = {hist_b, path_in_b};
  assign path_result_a = ~taps_a[tap_sel];
  assign path_result_b = ~taps_b[tap_sel];

  typedef struct {
    string name;
    int n; int s; int d;
    int cycles; int tc; int er; int ef; int ff; int pin;
    int sat_er; int sat_ef;
  } run_t;

  run_t runs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_run(input run_t r);
    int  cyc;
    logic got;
    repeat (20) @(negedge clk);
    num_trials    = 16'(r.n);
    settle_cycles = 8'(r.s);
    tap_sel       = 5'(r.d - 1);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (r.n > 0) check({r.name, " busy_after_start"}, int'(busy_a), 1);
    cyc = 0;
    got = done_a;
    while (!got && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1;
      got = done_a;
    end
    check({r.name, " done_seen"}, int'(got), 1);
    check({r.name, " cycles_to_done"}, cyc, r.cycles);
    check({r.name, " busy_in_done"}, int'(busy_a), 0);
    @(posedge clk);
    #1;
    check({r.name, " done_one_cycle"}, int'(done_a), 0);
    check({r.name, " trial_count"}, int'(trial_count_a), r.tc);
    check({r.name, " err_rise"}, int'(err_rise_a), r.er);
    check({r.name, " err_fall"}, int'(err_fall_a), r.ef);
    check({r.name, " first_fail"}, int'(first_fail_a), r.ff);
    check({r.name, " path_in"}, int'(path_in_a), r.pin);
    check({r.name, " sat_err_rise"}, int'(err_rise_b), r.sat_er);
    check({r.name, " sat_err_fall"}, int'(err_fall_b), r.sat_ef);
  endtask

  task automatic wait_trials(input int target, input string name);
    int guard;
    guard = 0;
    while (int'(trial_count_a) != target && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check({name, " reached_trial"}, int'(trial_count_a), target);
  endtask

  initial begin
    run_t rr;
    start = 1'b0; abort = 1'b0; num_trials = '0; settle_cycles = '0; tap_sel = 5'd1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy_a), 0);
    check("reset done", int'(done_a), 0);
    check("reset path_in", int'(path_in_a), 0);
    check("reset trial_count", int'(trial_count_a), 0);
    check("reset err_rise", int'(err_rise_a), 0);
    check("reset err_fall", int'(err_fall_a), 0);
    check("reset first_fail", int'(first_fail_a), 65535);
    @(negedge clk);
    rst_n = 1'b1;

    //          name          n   s  d  cyc tc er ef ff     pin ser sef
    runs[0] = '{"fast",      10, 4, 2, 60, 10, 0, 0, 65535, 0,  0,  0};
    runs[1] = '{"slow",      10, 4, 6, 60, 10, 5, 5, 0,     0,  3,  3};
    runs[2] = '{"bound_s4",   4, 4, 4, 24,  4, 0, 0, 65535, 0,  0,  0};
    runs[3] = '{"bound_s3",   4, 3, 4, 20,  4, 2, 2, 0,     0,  2,  2};
    runs[4] = '{"zero_n",     0, 4, 2,  0,  0, 0, 0, 65535, 0,  0,  0};
    runs[5] = '{"settle0",    2, 0, 2,  6,  2, 1, 1, 0,     0,  1,  1};
    runs[6] = '{"settle1",    2, 1, 2,  6,  2, 1, 1, 0,     0,  1,  1};
    runs[7] = '{"settle0_ok", 2, 0, 1,  6,  2, 0, 0, 65535, 0,  0,  0};
    for (int i = 0; i < 8; i++) do_run(runs[i]);

    // Abort during trial 3's WAIT on a slow path
    repeat (20) @(negedge clk);
    num_trials = 16'd10; settle_cycles = 8'd4; tap_sel = 5'd5;
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_trials(3, "abort");
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort busy_before", int'(busy_a), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort busy", int'(busy_a), 0);
    check("abort done", int'(done_a), 0);
    check("abort trial_count", int'(trial_count_a), 3);
    check("abort err_sum", int'(err_rise_a) + int'(err_fall_a), 3);
    check("abort err_rise", int'(err_rise_a), 2);
    check("abort path_in", int'(path_in_a), 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("abort no_done", int'(done_a) | int'(busy_a), 0);
    end
    rr = '{"after_abort", 2, 4, 2, 12, 2, 0, 0, 65535, 0, 0, 0};
    do_run(rr);

    // Asynchronous reset in the middle of trial 2's WAIT
    repeat (20) @(negedge clk);
    num_trials = 16'd10; settle_cycles = 8'd4; tap_sel = 5'd5;
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_trials(2, "rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst pre path_in", int'(path_in_a), 1);
    check("rst pre err_rise", int'(err_rise_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", int'(busy_a), 0);
    check("rst path_in", int'(path_in_a), 0);
    check("rst trial_count", int'(trial_count_a), 0);
    check("rst err_rise", int'(err_rise_a), 0);
    check("rst err_fall", int'(err_fall_a), 0);
    check("rst first_fail", int'(first_fail_a), 65535);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst stays_idle", int'(busy_a) | int'(done_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
